// File: rtl/rs_array.sv
// Reservation-station array: holds dispatched instructions until their operand
// tags resolve on the CDBs, then issues the oldest ready entry to execute.

`ifndef RS_SIZE
`define RS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package rs_pkg;
  localparam int TAG_W  = 6;
  localparam int CTRL_W = 8;

  typedef struct packed {
    logic                    busy;
    logic [CTRL_W-1:0]       ctrl_bits;
    logic [TAG_W-1:0]        tag;
    logic [`DATA_SIZE-1:0]   value_1;
    logic [`DATA_SIZE-1:0]   value_2;
    logic [TAG_W-1:0]        tag_1;
    logic [TAG_W-1:0]        tag_2;
    logic [`DATA_SIZE-1:0]   imm;
  } rs_entry;

  typedef struct packed {
    logic [TAG_W-1:0]        tag;
    logic [`DATA_SIZE-1:0]   value;
  } cdb;
endpackage

module rs_array
  import rs_pkg::*;
#(
  parameter int RS_SIZE   = `RS_SIZE,
  parameter int DATA_SIZE = `DATA_SIZE
) (
  input  logic    clk,
  input  logic    reset,
  input  rs_entry rse,
  input  logic    dispatch_valid,
  input  logic    flush,
  input  cdb      cdb1,
  input  cdb      cdb2,
  input  logic    fu_ready,
  output logic    issue_valid,
  output rs_entry issue_entry,
  output logic    rs_full,
  output int      rs_count
);

  localparam int SLOT_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  rs_entry            ent     [RS_SIZE];
  rs_entry            ent_nxt [RS_SIZE];
  logic [RS_SIZE-1:0] older   [RS_SIZE];
  logic [RS_SIZE-1:0] busy, ready, sel;
  logic [SLOT_W-1:0]  slot;
  logic               ins, iss;

  // Returns {tag, value} for one operand after snooping both CDBs; cdb1 wins ties.
  function automatic logic [TAG_W+DATA_SIZE-1:0] resolve(
    input logic [TAG_W-1:0]     t,
    input logic [DATA_SIZE-1:0] v,
    input cdb                   c1,
    input cdb                   c2
  );
    if (t != '0 && t == c1.tag) return {{TAG_W{1'b0}}, c1.value};
    if (t != '0 && t == c2.tag) return {{TAG_W{1'b0}}, c2.value};
    return {t, v};
  endfunction

  function automatic rs_entry wake(input rs_entry e, input cdb c1, input cdb c2);
    rs_entry w;
    w = e;
    {w.tag_1, w.value_1} = resolve(e.tag_1, e.value_1, c1, c2);
    {w.tag_2, w.value_2} = resolve(e.tag_2, e.value_2, c1, c2);
    return w;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      busy[i]  = ent[i].busy;
      ready[i] = ent[i].busy && (ent[i].tag_1 == '0) && (ent[i].tag_2 == '0);
    end
  end

  // Oldest-ready select: no other ready entry is older than the winner.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      sel[i] = ready[i] && ((older[i] & ready) == '0);
  end

  always_comb begin
    issue_entry = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (sel[i]) issue_entry = rs_entry'(issue_entry | ent[i]);
  end

  assign issue_valid = |ready;
  assign iss         = issue_valid && fu_ready;
  assign rs_full     = (rs_count == RS_SIZE);
  assign ins         = dispatch_valid && !rs_full && !flush;

  always_comb begin
    slot = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!busy[i]) slot = SLOT_W'(i);
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].busy) ent_nxt[i] = wake(ent[i], cdb1, cdb2);
      if (iss && sel[i]) ent_nxt[i].busy = 1'b0;
      if (ins && slot == SLOT_W'(i)) begin
        ent_nxt[i]      = wake(rse, cdb1, cdb2);
        ent_nxt[i].busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent[i]   <= '0;
        older[i] <= '0;
      end
      rs_count <= 0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= ent_nxt[i];
      // New entry is younger than everything still resident after this edge.
      if (ins) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (slot == SLOT_W'(i)) older[i] <= busy & ~(sel & {RS_SIZE{iss}});
          else                    older[i][slot] <= 1'b0;
        end
      end
      rs_count <= rs_count + int'(ins) - int'(iss);
    end
  end

endmodule

// File: tb/tb_rs_array.sv
// Self-checking bench for rs_array: directed vector table, hand sequences for
// full/ordering/flush, and randomized traffic against an age-ordered queue model.

module tb_rs_array;
  import rs_pkg::*;

  localparam int N = 8;

  logic    clk = 1'b0;
  logic    reset, dv, flush, fr;
  rs_entry rse;
  cdb      c1, c2;
  logic    iv, full;
  rs_entry ie;
  int      cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rs_array #(.RS_SIZE(N), .DATA_SIZE(32)) dut (
    .clk(clk), .reset(reset), .rse(rse), .dispatch_valid(dv), .flush(flush),
    .cdb1(c1), .cdb2(c2), .fu_ready(fr), .issue_valid(iv), .issue_entry(ie),
    .rs_full(full), .rs_count(cnt)
  );

  typedef struct {
    logic        rst, dv, fl, fr;
    logic [5:0]  etag, t1, t2;
    logic [31:0] v1, v2;
    logic [5:0]  c1t;
    logic [31:0] c1v;
    logic [5:0]  c2t;
    logic [31:0] c2v;
    logic        x_iv;
    logic [5:0]  x_tag;
    logic [31:0] x_v1, x_v2;
    int          x_cnt;
  } vec_t;

  rs_entry q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; dv = 1'b0; flush = 1'b0; fr = 1'b0;
    rse = '0; c1 = '0; c2 = '0;
  endtask

  function automatic rs_entry mk(input logic [5:0] tag, input logic [5:0] t1,
                                 input logic [5:0] t2, input logic [31:0] v1,
                                 input logic [31:0] v2);
    rs_entry e;
    e = '0;
    e.tag = tag; e.tag_1 = t1; e.tag_2 = t2; e.value_1 = v1; e.value_2 = v2;
    return e;
  endfunction

  function automatic rs_entry exp_ent(input logic [5:0] tag, input logic [31:0] v1,
                                      input logic [31:0] v2);
    rs_entry e;
    e = mk(tag, 6'd0, 6'd0, v1, v2);
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic chk_out(input string nm, input logic e_iv, input rs_entry e_ie, input int e_cnt);
    chk({nm, " issue_valid"}, 128'(iv), 128'(e_iv));
    chk({nm, " issue_entry"}, 128'(ie), 128'(e_ie));
    chk({nm, " rs_count"}, 128'(cnt), 128'(e_cnt));
    chk({nm, " rs_full"}, 128'(full), 128'(e_cnt == N));
  endtask

  function automatic vec_t row(input int rst, input int dv_i, input int fl, input int fr_i,
                               input int etag, input int t1, input int t2,
                               input int v1, input int v2, input int c1t, input int c1v,
                               input int c2t, input int c2v, input int xiv, input int xtag,
                               input int xv1, input int xv2, input int xcnt);
    vec_t r;
    r.rst = 1'(rst); r.dv = 1'(dv_i); r.fl = 1'(fl); r.fr = 1'(fr_i);
    r.etag = 6'(etag); r.t1 = 6'(t1); r.t2 = 6'(t2);
    r.v1 = 32'(v1); r.v2 = 32'(v2);
    r.c1t = 6'(c1t); r.c1v = 32'(c1v); r.c2t = 6'(c2t); r.c2v = 32'(c2v);
    r.x_iv = 1'(xiv); r.x_tag = 6'(xtag); r.x_v1 = 32'(xv1); r.x_v2 = 32'(xv2);
    r.x_cnt = xcnt;
    return r;
  endfunction

  // Reference model: q holds live entries oldest-first.
  function automatic rs_entry m_wake(input rs_entry e, input cdb a, input cdb b);
    rs_entry w;
    w = e;
    if (w.tag_1 != 0) begin
      if (w.tag_1 == a.tag)      begin w.value_1 = a.value; w.tag_1 = 0; end
      else if (w.tag_1 == b.tag) begin w.value_1 = b.value; w.tag_1 = 0; end
    end
    if (w.tag_2 != 0) begin
      if (w.tag_2 == a.tag)      begin w.value_2 = a.value; w.tag_2 = 0; end
      else if (w.tag_2 == b.tag) begin w.value_2 = b.value; w.tag_2 = 0; end
    end
    return w;
  endfunction

  function automatic int m_first_ready();
    for (int i = 0; i < q.size(); i++)
      if (q[i].tag_1 == 0 && q[i].tag_2 == 0) return i;
    return -1;
  endfunction

  task automatic model_step();
    int      s;
    bit      was_full;
    rs_entry e;
    if (reset || flush) begin
      q.delete();
    end else begin
      s = m_first_ready();
      was_full = (q.size() == N);
      if (s >= 0 && fr) q.delete(s);
      foreach (q[i]) q[i] = m_wake(q[i], c1, c2);
      if (dv && !was_full) begin
        e = m_wake(rse, c1, c2);
        e.busy = 1'b1;
        q.push_back(e);
      end
    end
  endtask

  task automatic model_check(input string nm);
    int s;
    s = m_first_ready();
    if (s >= 0) chk_out(nm, 1'b1, q[s], q.size());
    else        chk_out(nm, 1'b0, '0, q.size());
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = row(1,1,0,0, 1,0,0, 0,0,      0,0,     0,0,      0,0,0,0,0);
    tbl[1]  = row(1,1,0,0, 1,0,0, 0,0,      0,0,     0,0,      0,0,0,0,0);
    tbl[2]  = row(0,1,0,1, 3,0,0, 5,7,      0,0,     0,0,      1,3,5,7,1);
    tbl[3]  = row(0,0,0,1, 0,0,0, 0,0,      0,0,     0,0,      0,0,0,0,0);
    tbl[4]  = row(0,1,0,1, 4,2,0, 0,'h22,   0,0,     0,0,      0,0,0,0,1);
    tbl[5]  = row(0,0,0,1, 0,0,0, 0,0,      0,0,     0,0,      0,0,0,0,1);
    tbl[6]  = row(0,0,0,1, 0,0,0, 0,0,      2,'h10,  0,0,      1,4,'h10,'h22,1);
    tbl[7]  = row(0,0,0,1, 0,0,0, 0,0,      0,0,     0,0,      0,0,0,0,0);
    tbl[8]  = row(0,1,0,0, 5,0,6, 1,0,      0,0,     6,'hAB,   1,5,1,'hAB,1);
    tbl[9]  = row(0,0,0,1, 0,0,0, 0,0,      0,0,     0,0,      0,0,0,0,0);
    tbl[10] = row(0,1,0,0, 7,0,6, 0,0,      6,1,     6,2,      1,7,0,1,1);
    tbl[11] = row(0,0,0,1, 0,0,0, 0,0,      0,0,     0,0,      0,0,0,0,0);

    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; dv = tbl[i].dv; flush = tbl[i].fl; fr = tbl[i].fr;
      rse = mk(tbl[i].etag, tbl[i].t1, tbl[i].t2, tbl[i].v1, tbl[i].v2);
      c1 = '{tag: tbl[i].c1t, value: tbl[i].c1v};
      c2 = '{tag: tbl[i].c2t, value: tbl[i].c2v};
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].x_iv,
              tbl[i].x_iv ? exp_ent(tbl[i].x_tag, tbl[i].x_v1, tbl[i].x_v2) : '0,
              tbl[i].x_cnt);
    end

    // Fill to capacity, drop extra inserts, drain in age order.
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      dv = 1'b1; rse = mk(6'(k), 6'd0, 6'd0, 32'(k * 16), 32'd0);
      tick();
    end
    dv = 1'b0;
    chk_out("full", 1'b1, exp_ent(6'd1, 32'd16, 32'd0), 8);
    dv = 1'b1; rse = mk(6'd9, 6'd0, 6'd0, 32'd144, 32'd0);
    tick();
    dv = 1'b0;
    chk_out("drop9", 1'b1, exp_ent(6'd1, 32'd16, 32'd0), 8);
    dv = 1'b1; fr = 1'b1; rse = mk(6'd10, 6'd0, 6'd0, 32'd160, 32'd0);
    tick();
    dv = 1'b0; fr = 1'b0;
    chk_out("drop_on_issue", 1'b1, exp_ent(6'd2, 32'd32, 32'd0), 7);
    for (int k = 2; k <= 8; k++) begin
      chk($sformatf("order%0d tag", k), 128'(ie.tag), 128'(k));
      fr = 1'b1;
      tick();
      fr = 1'b0;
      chk($sformatf("order%0d count", k), 128'(cnt), 128'(8 - k));
    end
    chk_out("drained", 1'b0, '0, 0);

    // Younger ready entry bypasses an older waiting one; then flush beats insert.
    dv = 1'b1; rse = mk(6'd10, 6'd9, 6'd0, 32'd0, 32'd5);
    tick();
    rse = mk(6'd11, 6'd0, 6'd0, 32'd1, 32'd2);
    tick();
    dv = 1'b0;
    chk_out("ooo_b", 1'b1, exp_ent(6'd11, 32'd1, 32'd2), 2);
    fr = 1'b1;
    tick();
    fr = 1'b0;
    chk_out("ooo_a_wait", 1'b0, '0, 1);
    c1 = '{tag: 6'd9, value: 32'h99};
    tick();
    c1 = '0;
    chk_out("ooo_a", 1'b1, exp_ent(6'd10, 32'h99, 32'd5), 1);
    fr = 1'b1;
    tick();
    fr = 1'b0;
    chk_out("ooo_done", 1'b0, '0, 0);
    for (int k = 12; k <= 14; k++) begin
      dv = 1'b1; rse = mk(6'(k), 6'd0, 6'd0, 32'(k), 32'd0);
      tick();
    end
    dv = 1'b0;
    chk_out("refill", 1'b1, exp_ent(6'd12, 32'd12, 32'd0), 3);
    flush = 1'b1; dv = 1'b1; rse = mk(6'd15, 6'd0, 6'd0, 32'd15, 32'd0);
    tick();
    flush = 1'b0; dv = 1'b0;
    chk_out("flush", 1'b0, '0, 0);
    tick();
    chk_out("post_flush", 1'b0, '0, 0);

    // Randomized traffic against the queue model.
    idle_inputs();
    reset = 1'b1;
    model_step();
    tick();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      reset = ($urandom_range(0, 255) == 0);
      flush = ($urandom_range(0, 63) == 0);
      dv    = ($urandom_range(0, 9) < 6);
      fr    = 1'($urandom_range(0, 1));
      rse.busy      = 1'($urandom_range(0, 1));
      rse.ctrl_bits = 8'($urandom);
      rse.tag       = 6'($urandom_range(1, 63));
      rse.tag_1     = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 7)) : 6'd0;
      rse.tag_2     = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 7)) : 6'd0;
      rse.value_1   = $urandom;
      rse.value_2   = $urandom;
      rse.imm       = $urandom;
      c1.tag   = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 7));
      c1.value = $urandom;
      c2.tag   = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 7));
      c2.value = $urandom;
      model_step();
      tick();
      model_check($sformatf("rand%0d", cyc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
